// File: rtl/hashout_arbiter_pkg.sv
// Shared miner definitions: arbiter states, beat geometry and small helpers
// used by the hash-out arbiter and its comparator interface.
package hashout_arbiter_pkg;

   localparam int unsigned WORD_W     = 64;
   localparam int unsigned BEATS      = 4;
   localparam int unsigned BEAT_W     = $clog2(BEATS);
   localparam int unsigned HASH_W     = WORD_W * BEATS;
   localparam int unsigned NONCE_W    = 32;
   localparam int unsigned CORE_IDX_W = 3;
   localparam int unsigned LOST_W     = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STREAM,
      ST_WAIT_RESULT,
      ST_SAMPLE
   } arb_state_e;

   function automatic logic [LOST_W-1:0] sat_inc(input logic [LOST_W-1:0] v);
      return (&v) ? v : v + LOST_W'(1);
   endfunction

endpackage

// File: rtl/hashout_arbiter_if.sv
// Beat/result handshake between the hash-out arbiter (master) and the
// shared heavy-hash comparator (slave).
interface hashout_arbiter_if;
   import hashout_arbiter_pkg::*;

   logic              cmp_re;
   logic [WORD_W-1:0] cmp_din;
   logic              cmp_din_we;
   logic              cmp_nonce_re;
   logic              cmp_result;

   modport master (
      input  cmp_re,
      input  cmp_nonce_re,
      input  cmp_result,
      output cmp_din,
      output cmp_din_we
   );

   modport slave (
      output cmp_re,
      output cmp_nonce_re,
      output cmp_result,
      input  cmp_din,
      input  cmp_din_we
   );

endinterface

// File: rtl/hashout_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester found after the
// last-grant pointer, returned as both one-hot and binary index.
module rr_arbiter #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] last_i,
   output logic [N-1:0]     gnt_oh_o,
   output logic [IDX_W-1:0] gnt_idx_o,
   output logic             gnt_valid_o
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      gnt_oh_o    = '0;
      gnt_idx_o   = '0;
      gnt_valid_o = 1'b0;
      cand        = '0;
      // k = N wraps back to last_i itself, so a lone requester can re-win
      for (int unsigned k = 1; k <= N; k++) begin
         cand = IDX_W'((32'(last_i) + k) % N);
         if (!gnt_valid_o && req_i[cand]) begin
            gnt_valid_o    = 1'b1;
            gnt_idx_o      = cand;
            gnt_oh_o[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/hashout_arbiter.sv
// Shares one heavy-hash comparator among NUM_CORES cores: grants a core,
// streams its hash as four 64-bit beats, then records golden results.
module hashout_arbiter
   import hashout_arbiter_pkg::*;
#(
   parameter int unsigned NUM_CORES = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          stop,
   input  logic [NUM_CORES-1:0]          core_valid,
   input  logic [NUM_CORES*HASH_W-1:0]   core_hash,
   input  logic [NUM_CORES*NONCE_W-1:0]  core_nonce,
   output logic [NUM_CORES-1:0]          core_pop,
   hashout_arbiter_if.master             cmp,
   output logic                          found,
   output logic [NONCE_W-1:0]            golden_nonce,
   output logic [CORE_IDX_W-1:0]         golden_core,
   input  logic                          found_ack,
   output logic [31:0]                   dispatched,
   output logic [LOST_W-1:0]             lost
);

   localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   arb_state_e                state_q, state_d;
   logic [BEAT_W-1:0]         beat_q, beat_d;
   logic [IDX_W-1:0]          grant_q, grant_d;
   logic [NUM_CORES-1:0]      grant_oh_q, grant_oh_d;
   logic [IDX_W-1:0]          last_q, last_d;
   logic [NONCE_W-1:0]        nonce_q, nonce_d;
   logic [NUM_CORES-1:0]      pop_q, pop_d;
   logic [31:0]               disp_q, disp_d;
   logic                      found_q, found_d;
   logic [NONCE_W-1:0]        gnonce_q, gnonce_d;
   logic [CORE_IDX_W-1:0]     gcore_q, gcore_d;
   logic [LOST_W-1:0]         lost_q, lost_d;

   logic [WORD_W-1:0]         word_a  [NUM_CORES][BEATS];
   logic [NONCE_W-1:0]        nonce_a [NUM_CORES];

   logic [NUM_CORES-1:0]      arb_oh;
   logic [IDX_W-1:0]          arb_idx;
   logic                      arb_valid;
   logic                      stream_act;
   logic                      beat_fire;

   for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
      assign nonce_a[c] = core_nonce[c*NONCE_W +: NONCE_W];
      for (genvar b = 0; b < BEATS; b++) begin : g_beat
         assign word_a[c][b] = core_hash[c*HASH_W + b*WORD_W +: WORD_W];
      end
   end

   rr_arbiter #(
      .N     (NUM_CORES),
      .IDX_W (IDX_W)
   ) u_rr (
      .req_i       (core_valid),
      .last_i      (last_q),
      .gnt_oh_o    (arb_oh),
      .gnt_idx_o   (arb_idx),
      .gnt_valid_o (arb_valid)
   );

   // A beat is only accepted when no abort or reset is pending this cycle
   assign stream_act     = (state_q == ST_STREAM) && !rst;
   assign beat_fire      = stream_act && cmp.cmp_re && !stop;
   assign cmp.cmp_din_we = beat_fire;
   assign cmp.cmp_din    = stream_act ? word_a[grant_q][beat_q] : '0;

   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      grant_d    = grant_q;
      grant_oh_d = grant_oh_q;
      last_d     = last_q;
      nonce_d    = nonce_q;
      pop_d      = '0;
      disp_d     = disp_q;
      found_d    = found_ack ? 1'b0 : found_q;
      gnonce_d   = gnonce_q;
      gcore_d    = gcore_q;
      lost_d     = lost_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start && !stop && arb_valid) begin
               grant_d    = arb_idx;
               grant_oh_d = arb_oh;
               beat_d     = '0;
               state_d    = ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (beat_fire) begin
               if (beat_q == BEAT_W'(BEATS - 1)) begin
                  // Pointer advances only on completion so an aborted core is retried first
                  pop_d   = grant_oh_q;
                  nonce_d = nonce_a[grant_q];
                  disp_d  = disp_q + 32'd1;
                  last_d  = grant_q;
                  beat_d  = '0;
                  state_d = ST_WAIT_RESULT;
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
         end
         ST_WAIT_RESULT: begin
            if (cmp.cmp_nonce_re) state_d = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            if (!stop && cmp.cmp_result) begin
               if (!found_q) begin
                  found_d  = 1'b1;
                  gnonce_d = nonce_q;
                  gcore_d  = CORE_IDX_W'(grant_q);
               end else begin
                  lost_d = sat_inc(lost_q);
               end
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (stop) begin
         state_d = ST_IDLE;
         beat_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         beat_q     <= '0;
         grant_q    <= '0;
         grant_oh_q <= '0;
         last_q     <= IDX_W'(NUM_CORES - 1);
         nonce_q    <= '0;
         pop_q      <= '0;
         disp_q     <= '0;
         found_q    <= 1'b0;
         gnonce_q   <= '0;
         gcore_q    <= '0;
         lost_q     <= '0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         grant_q    <= grant_d;
         grant_oh_q <= grant_oh_d;
         last_q     <= last_d;
         nonce_q    <= nonce_d;
         pop_q      <= pop_d;
         disp_q     <= disp_d;
         found_q    <= found_d;
         gnonce_q   <= gnonce_d;
         gcore_q    <= gcore_d;
         lost_q     <= lost_d;
      end
   end

   assign core_pop     = pop_q;
   assign found        = found_q;
   assign golden_nonce = gnonce_q;
   assign golden_core  = gcore_q;
   assign dispatched   = disp_q;
   assign lost         = lost_q;

endmodule

// File: tb/tb_hashout_arbiter.sv
// Directed bench for hashout_arbiter with a transaction-level reference
// model compared against the DUT on every falling clock edge.
module tb_hashout_arbiter;
   import hashout_arbiter_pkg::*;

   localparam int N = 4;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                start = 1'b0;
   logic                stop = 1'b0;
   logic                found_ack = 1'b0;
   logic [N-1:0]        core_valid = '0;
   logic [N*256-1:0]    core_hash = '0;
   logic [N*32-1:0]     core_nonce = '0;
   logic [N-1:0]        core_pop;
   logic                found;
   logic [31:0]         golden_nonce;
   logic [2:0]          golden_core;
   logic [31:0]         dispatched;
   logic [7:0]          lost;

   hashout_arbiter_if cmp_if ();

   hashout_arbiter #(.NUM_CORES(N)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .stop         (stop),
      .core_valid   (core_valid),
      .core_hash    (core_hash),
      .core_nonce   (core_nonce),
      .core_pop     (core_pop),
      .cmp          (cmp_if),
      .found        (found),
      .golden_nonce (golden_nonce),
      .golden_core  (golden_core),
      .found_ack    (found_ack),
      .dispatched   (dispatched),
      .lost         (lost)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] hw(input int c, input int b);
      return 64'hA5A5_0000_0000_0000 | (64'(c) << 16) | (64'(b) << 8) | 64'(c * 4 + b);
   endfunction

   // Reference model: who owns the comparator and how far its hash has gone
   int          m_grant = -1;
   int          m_beats = 0;
   bit          m_wait = 1'b0;
   bit          m_dec = 1'b0;
   int          m_last = N - 1;
   bit          m_found = 1'b0;
   bit          m_old_found;
   logic [31:0] m_gn = '0;
   int          m_gc = 0;
   logic [31:0] m_disp = '0;
   int          m_lost = 0;
   logic [N-1:0] m_pop = '0;
   logic [31:0] m_nonce = '0;
   int          m_core = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_grant = -1; m_beats = 0; m_wait = 0; m_dec = 0; m_last = N - 1;
         m_found = 0; m_gn = '0; m_gc = 0; m_disp = '0; m_lost = 0; m_pop = '0;
      end else begin
         m_old_found = m_found;
         m_pop = '0;
         if (found_ack) m_found = 0;
         if (stop) begin
            m_grant = -1; m_beats = 0; m_wait = 0; m_dec = 0;
         end else if (m_dec) begin
            if (cmp_if.cmp_result) begin
               if (!m_old_found) begin
                  m_found = 1; m_gn = m_nonce; m_gc = m_core;
               end else if (m_lost < 255) begin
                  m_lost++;
               end
            end
            m_dec = 0;
         end else if (m_wait) begin
            if (cmp_if.cmp_nonce_re) begin m_wait = 0; m_dec = 1; end
         end else if (m_grant >= 0) begin
            if (cmp_if.cmp_re) begin
               m_beats++;
               if (m_beats == 4) begin
                  m_pop = N'(1) << m_grant;
                  m_nonce = core_nonce[m_grant*32 +: 32];
                  m_disp = m_disp + 32'd1;
                  m_last = m_grant; m_core = m_grant;
                  m_grant = -1; m_beats = 0; m_wait = 1;
               end
            end
         end else if (start && core_valid != '0) begin
            for (int k = 1; k <= N; k++) begin
               if (m_grant < 0 && core_valid[(m_last + k) % N]) m_grant = (m_last + k) % N;
            end
            m_beats = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         bit exp_we;
         exp_we = (m_grant >= 0) && cmp_if.cmp_re && !stop && !rst;
         chk("m_din_we", 64'(cmp_if.cmp_din_we), 64'(exp_we));
         if (exp_we) chk("m_din", cmp_if.cmp_din, hw(m_grant, m_beats));
         chk("m_pop", 64'(core_pop), 64'(m_pop));
         chk("m_found", 64'(found), 64'(m_found));
         chk("m_golden_nonce", 64'(golden_nonce), 64'(m_gn));
         chk("m_golden_core", 64'(golden_core), 64'(m_gc));
         chk("m_dispatched", 64'(dispatched), 64'(m_disp));
         chk("m_lost", 64'(lost), 64'(m_lost));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_nonce(input int c, input logic [31:0] v);
      core_nonce[c*32 +: 32] = v;
   endtask

   task automatic decide(input bit res, input bit ack);
      cmp_if.cmp_nonce_re = 1'b1;
      tick();
      cmp_if.cmp_nonce_re = 1'b0;
      cmp_if.cmp_result = res;
      found_ack = ack;
      tick();
      cmp_if.cmp_result = 1'b0;
      found_ack = 1'b0;
   endtask

   // Assumes IDLE with start=1 and cmp_re=1; first tick is the grant edge
   task automatic do_txn(input int core, input bit res, input bit ack);
      tick();
      for (int b = 0; b < 4; b++) begin
         chk("txn_we", 64'(cmp_if.cmp_din_we), 64'd1);
         chk("txn_word", cmp_if.cmp_din, hw(core, b));
         tick();
      end
      chk("txn_pop", 64'(core_pop), 64'(N'(1) << core));
      decide(res, ack);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int nwe;
      cmp_if.cmp_re = 1'b1;
      cmp_if.cmp_nonce_re = 1'b0;
      cmp_if.cmp_result = 1'b0;
      for (int c = 0; c < N; c++) begin
         for (int b = 0; b < 4; b++) core_hash[c*256 + b*64 +: 64] = hw(c, b);
         set_nonce(c, 32'h1000_0000 + 32'(c));
      end

      @(posedge clk); #1;
      chk_en = 1'b1;
      tick(); tick();
      chk("rst_found", 64'(found), 64'd0);
      chk("rst_dispatched", 64'(dispatched), 64'd0);
      chk("rst_lost", 64'(lost), 64'd0);
      chk("rst_pop", 64'(core_pop), 64'd0);
      chk("rst_we", 64'(cmp_if.cmp_din_we), 64'd0);
      chk("rst_din", cmp_if.cmp_din, 64'd0);
      rst = 1'b0;

      // Round robin over cores 0 and 2
      core_valid = 4'b0101;
      start = 1'b1;
      do_txn(0, 0, 0);
      do_txn(2, 0, 0);
      do_txn(0, 0, 0);
      chk("rr_dispatched", 64'(dispatched), 64'd3);
      start = 1'b0;
      tick();

      // Toggling cmp_re on core 1
      core_valid = 4'b0010;
      start = 1'b1;
      tick();
      nwe = 0;
      for (int k = 0; k < 12; k++) begin
         cmp_if.cmp_re = (k % 2 == 0);
         #1;
         if (k == 7) chk("tog_pop", 64'(core_pop), 64'b0010);
         if (cmp_if.cmp_din_we) begin
            chk("tog_re_high", 64'(cmp_if.cmp_re), 64'd1);
            chk("tog_word", cmp_if.cmp_din, hw(1, nwe));
            nwe++;
         end
         @(posedge clk); #1;
      end
      chk("tog_beats", 64'(nwe), 64'd4);
      cmp_if.cmp_re = 1'b1;
      decide(0, 0);

      // Golden result from core 1, then a lost one, then ack
      set_nonce(1, 32'hDEADBEEF);
      do_txn(1, 1, 0);
      chk("gold_found", 64'(found), 64'd1);
      chk("gold_nonce", 64'(golden_nonce), 64'hDEADBEEF);
      chk("gold_core", 64'(golden_core), 64'd1);
      set_nonce(1, 32'h1234_5678);
      do_txn(1, 1, 0);
      chk("lost_one", 64'(lost), 64'd1);
      chk("lost_keep_nonce", 64'(golden_nonce), 64'hDEADBEEF);
      start = 1'b0;
      found_ack = 1'b1;
      tick();
      found_ack = 1'b0;
      chk("ack_clear", 64'(found), 64'd0);

      // Set and ack in the same cycle: set wins
      set_nonce(1, 32'hCAFE_F00D);
      start = 1'b1;
      do_txn(1, 1, 1);
      chk("ackset_found", 64'(found), 64'd1);
      chk("ackset_nonce", 64'(golden_nonce), 64'hCAFEF00D);
      chk("ackset_lost", 64'(lost), 64'd1);

      // Abort after three beats of core 2, then restart from beat 0
      core_valid = 4'b0101;
      tick();
      for (int b = 0; b < 3; b++) begin
         chk("abort_word", cmp_if.cmp_din, hw(2, b));
         tick();
      end
      stop = 1'b1;
      #1;
      chk("abort_we", 64'(cmp_if.cmp_din_we), 64'd0);
      @(posedge clk); #1;
      stop = 1'b0;
      chk("abort_pop", 64'(core_pop), 64'd0);
      chk("abort_dispatched", 64'(dispatched), 64'd7);
      do_txn(2, 0, 0);
      chk("restart_dispatched", 64'(dispatched), 64'd8);

      // Saturate lost
      core_valid = 4'b0001;
      for (int i = 0; i < 300; i++) begin
         do_txn(0, 1, 0);
         if (i == 252) chk("lost_254", 64'(lost), 64'd254);
      end
      chk("lost_sat", 64'(lost), 64'd255);
      chk("sat_nonce", 64'(golden_nonce), 64'hCAFEF00D);

      // Reset in the middle of a stream
      core_valid = 4'b1111;
      tick();
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("rstmid_we", 64'(cmp_if.cmp_din_we), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rstmid_pop", 64'(core_pop), 64'd0);
      chk("rstmid_dispatched", 64'(dispatched), 64'd0);
      chk("rstmid_found", 64'(found), 64'd0);
      do_txn(0, 0, 0);
      start = 1'b0;
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hashout_arbiter.md
HASHOUT_ARBITER -- requirements
Module: hashout_arbiter

Interface
REQ-001 Parameter: NUM_CORES, default 4, number of heavy-hash cores sharing one comparator (2..8).
REQ-002 Port: clk  in  1  global clock; the block SHALL use this single clock.
REQ-003 Port: rst  in  1  global reset; synchronous, active-high.
REQ-004 Port: start  in  1  level; arbitration runs only while high.
REQ-005 Port: stop  in  1  abort; same net that drives the comparator's stop.
REQ-006 Port: core_valid  in  NUM_CORES  core i holds a complete 256-bit hash and its nonce.
REQ-007 Port: core_hash  in  NUM_CORES*256  core i hash at [256i+255:256i], as four 64-bit words, word 0 lowest.
REQ-008 Port: core_nonce  in  NUM_CORES*32  core i nonce at [32i+31:32i].
REQ-009 Port: core_pop  out  NUM_CORES  one-cycle pop pulse to core i once its hash is consumed.
REQ-010 Port: cmp_re  in  1  comparator heavy_hash_re (beat request).
REQ-011 Port: cmp_din  out  64  beat data to comparator heavy_hash_din.
REQ-012 Port: cmp_din_we  out  1  beat valid to comparator heavy_hash_din_we.
REQ-013 Port: cmp_nonce_re  in  1  comparator nonce_fifo_re (result-decision strobe).
REQ-014 Port: cmp_result  in  1  comparator result.
REQ-015 Port: found  out  1  sticky golden-nonce flag.
REQ-016 Port: golden_nonce  out  32  nonce that produced the winning hash.
REQ-017 Port: golden_core  out  3  index of the winning core.
REQ-018 Port: found_ack  in  1  clears found.
REQ-019 Port: dispatched  out  32  count of hashes fully streamed to the comparator.
REQ-020 Port: lost  out  8  saturating count of golden results dropped while found was already set.

Function
REQ-021 States SHALL be IDLE, STREAM, WAIT_RESULT and SAMPLE.
REQ-022 IDLE: when start=1, stop=0 and any core_valid bit is set, the block SHALL grant exactly one core round-robin, searching from (last_grant+1) mod NUM_CORES, latch its index, and go to STREAM with beat=0.
REQ-023 STREAM: cmp_din_we SHALL equal cmp_re (combinational) and cmp_din SHALL be word[beat] of the granted core, unswapped; beat increments on each cmp_din_we.
REQ-024 On the fourth beat (beat=3 with cmp_din_we), the block SHALL pulse core_pop[grant] for exactly one cycle, latch the granted nonce, increment dispatched (wrapping at 2^32), and go to WAIT_RESULT.
REQ-025 cmp_din_we SHALL be 0 outside STREAM; core_pop SHALL never pulse for a core whose stream was aborted.
REQ-026 WAIT_RESULT: on cmp_nonce_re=1, the block SHALL go to SAMPLE.
REQ-027 SAMPLE, one cycle: cmp_result=1 with found=0 SHALL set found and load golden_nonce/golden_core; cmp_result=1 with found=1 SHALL increment lost (saturating at 255) and leave golden_* unchanged; the next state is IDLE.
REQ-028 found_ack=1 SHALL clear found next cycle; a simultaneous set in SAMPLE SHALL take priority (found stays 1, new nonce loaded).
REQ-029 stop=1 in any state SHALL return to IDLE next cycle with beat=0, no pop, and counters and golden_* unchanged.
REQ-030 core_valid dropping mid-STREAM SHALL be ignored; the grant is held until pop or stop.
REQ-031 With a single requester, back-to-back grants to the same core SHALL be allowed.

Reset
REQ-032 rst SHALL force IDLE, beat=0, last_grant=NUM_CORES-1, found=0, golden_nonce=0, golden_core=0, dispatched=0, lost=0, core_pop=0, cmp_din=0 and cmp_din_we=0, so the first grant after reset goes to core 0.
REQ-033 rst asserted mid-STREAM SHALL pop nothing.

Structure
REQ-034 The state enum, the beat count (4) and the word width (64) SHALL be defined in the shared miner package.
REQ-035 One sub-module, rr_arbiter (NUM_CORES requests, last-grant pointer, one-hot and binary grant), SHALL be instantiated.

Verification
REQ-036 Scenario: reset, core_valid=4'b0101, cmp_re held high -> core 0 streams 4 beats on consecutive cycles, then core_pop=0001; the next grant goes to core 2.
REQ-037 Scenario: cmp_re toggling 1,0,1,0... -> exactly 4 beats, each in a cmp_re=1 cycle, in word order 0..3.
REQ-038 Scenario: core 1, nonce 0xDEADBEEF, cmp_result=1 in SAMPLE -> found=1, golden_nonce=0xDEADBEEF, golden_core=1.
REQ-039 Scenario: second golden result without found_ack -> lost=1, golden_nonce unchanged; then found_ack -> found=0.
REQ-040 Scenario: stop asserted after beat 2 -> IDLE, no core_pop, dispatched unchanged; restart -> the same core re-streams from beat 0.
REQ-041 Scenario: 300 golden results without found_ack -> lost saturates at 255.
